dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single byte-addressed data memory port between two requesters: m0 (CPU load/store
//  unit) and m1 (memory loader/debug port). Round-robin arbitration, one transaction per 3 cycles.
//  Sits between both requesters and the data memory: drives its A/WD/WE/ADTP inputs, samples RD.
//  Out-of-range requests are rejected with an error response and never touch memory.
// PARAMETERS
//  ADDRESS_WIDTH  32            address width, all ports
//  DATA_WIDTH     32            data width, all ports
//  ADDR_LIMIT     32'h0001FFFF  highest legal byte address; word access needs addr+3 <= ADDR_LIMIT
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst_n       in   1   asynchronous active-low reset
//  mX_req      in   1   X=0,1: request; held high with fields stable until mX_gnt
//  mX_we       in   1   1 = write, 0 = read
//  mX_adtp     in   1   0 = 32-bit word access, 1 = 8-bit byte access (zero-extended read)
//  mX_addr     in   32  byte address
//  mX_wdata    in   32  write data (byte access uses [7:0])
//  mX_gnt      out  1   one-cycle pulse: request latched, requester may change fields
//  mX_rvalid   out  1   one-cycle pulse: transaction complete (reads and writes)
//  mX_rdata    out  32  read data, valid with mX_rvalid; 0 for writes and errors
//  mX_err      out  1   valid with mX_rvalid: address out of range
//  mem_a       out  32  to data memory A
//  mem_wd      out  32  to data memory WD
//  mem_we      out  1   to data memory WE
//  mem_adtp    out  1   to data memory ADTP
//  mem_rd      in   32  from data memory RD (combinational read)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, rr_ptr=0, latched regs 0; all outputs 0 (mem_we=0 so
//    an in-flight write is dropped). Reset mid-transaction: no rvalid is ever issued for it.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE.
//  - IDLE: mem_* = 0. If exactly one mX_req: select X. If both: select rr_ptr. On select, latch
//    owner, we, adtp, addr, wdata, err = out-of-range(addr, adtp); next = ACCESS. No req: stay.
//  - ACCESS (1 cycle): mX_gnt=1 for owner. mem_a/mem_wd/mem_adtp driven from latched regs;
//    mem_we = we & ~err (write lands at end of this cycle). Read: rdata_q <= err ? 0 : mem_rd;
//    write: rdata_q <= 0. next = RESP.
//  - RESP (1 cycle): owner mX_rvalid=1, mX_rdata=rdata_q, mX_err=err_q; mem_we=0;
//    rr_ptr <= ~owner (toggled even if other requester idle); next = IDLE.
//  - Latency: req sampled in cycle N -> gnt in N+1 -> rvalid in N+2. Next grant earliest N+4.
//  - Non-owner outputs always 0; gnt/rvalid never asserted to both requesters in one cycle.
//  - Range check: byte: addr > ADDR_LIMIT; word: addr > ADDR_LIMIT-3. No alignment check
//    (memory supports unaligned words). Address compare is unsigned, no wrap.
//  - req dropped before gnt: already-latched transaction still completes (requester contract).
// STRUCTURE
//  - Package dmem_arb_pkg: state_t enum {IDLE, ACCESS, RESP}; dmem_req_t struct
//    {we, adtp, addr, wdata}; ADDR_LIMIT default constant.
//  - Sub-module dmem_rr_pick: 2-way round-robin picker (req[1:0], rr_ptr -> valid, sel), combinational.
//  - Top: FSM, latch registers, output muxing.
// TESTING
//  1. m0 word write addr 0x10000 data 0xDEADBEEF, then word read 0x10000 -> m0_rdata 0xDEADBEEF,
//     err 0, gnt->rvalid 1 cycle apart.
//  2. m1 byte write 0x10002 data 0x55, word read 0x10000 -> 0xDE55BEEF; byte read 0x10002 -> 0x00000055.
//  3. m0 and m1 req together from reset -> m0 served first, then m1; repeat both -> m1 then m0.
//  4. m0 word write 0x1FFFE -> m0_err 1, mem_we never 1; byte read 0x1FFFF -> err 0.
//  5. rst_n low during ACCESS of a write -> mem_we 0 immediately, no rvalid, FSM IDLE, memory unchanged.
//  6. m1 continuous req with m0 idle -> m1 granted every 3 cycles; m0 req mid-stream -> m0 granted next.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Data-memory arbiter shared types.
// Transaction bundle, FSM states and the address range check.
package dmem_arb_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] ADDR_LIMIT_DEF = 32'h0001_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic          we;
    logic          adtp;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dmem_req_t;

  // Word needs addr+3 <= limit; compare against limit-3 to avoid wrap.
  function automatic logic out_of_range(
    input logic [AW-1:0] addr,
    input logic          adtp,
    input logic [AW-1:0] limit
  );
    if (adtp) return addr > limit;
    return addr > (limit - 32'd3);
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side data-memory port.
// master = requester, slave = arbiter.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic          req;
  logic          we;
  logic          adtp;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req, we, adtp, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, adtp, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker.
// rr_ptr only matters when both requesters are active.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       valid,
  output logic       sel
);
  always_comb begin
    valid = |req;
    sel   = 1'b0;
    unique case (1'b1)
      req[1] && req[0]:  sel = rr_ptr;
      req[1] && !req[0]: sel = 1'b1;
      default:           sel = 1'b0;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data-memory port.
// IDLE -> ACCESS -> RESP, one transaction every 3 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int              ADDRESS_WIDTH = AW,
  parameter int              DATA_WIDTH    = DW,
  parameter logic [AW-1:0]   ADDR_LIMIT    = ADDR_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmem_arbiter_if.slave            m0,
  dmem_arbiter_if.slave            m1,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic                     mem_we,
  output logic                     mem_adtp,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);
  state_t                state;
  dmem_req_t             cur_q;
  dmem_req_t             pick_req;
  logic                  owner;
  logic                  rr_ptr;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  pick_valid;
  logic                  pick_sel;
  logic                  acc;
  logic                  rsp;

  dmem_rr_pick u_pick (
    .req    ({m1.req, m0.req}),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .sel    (pick_sel)
  );

  always_comb begin
    pick_req = '0;
    if (pick_sel) begin
      pick_req.we    = m1.we;
      pick_req.adtp  = m1.adtp;
      pick_req.addr  = m1.addr;
      pick_req.wdata = m1.wdata;
    end else begin
      pick_req.we    = m0.we;
      pick_req.adtp  = m0.adtp;
      pick_req.addr  = m0.addr;
      pick_req.wdata = m0.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_q   <= '0;
      owner   <= 1'b0;
      rr_ptr  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_sel;
            cur_q <= pick_req;
            err_q <= out_of_range(pick_req.addr,
                                  pick_req.adtp,
                                  ADDR_LIMIT);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= (cur_q.we || err_q) ? '0 : mem_rd;
          state   <= RESP;
        end
        RESP: begin
          // Toggle unconditionally so the other side wins next tie.
          rr_ptr <= ~owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc = (state == ACCESS);
  assign rsp = (state == RESP);

  assign mem_a    = acc ? cur_q.addr  : '0;
  assign mem_wd   = acc ? cur_q.wdata : '0;
  assign mem_adtp = acc & cur_q.adtp;
  assign mem_we   = acc & cur_q.we & ~err_q;

  assign m0.gnt    = acc & ~owner;
  assign m1.gnt    = acc & owner;
  assign m0.rvalid = rsp & ~owner;
  assign m1.rvalid = rsp & owner;
  assign m0.err    = rsp & ~owner & err_q;
  assign m1.err    = rsp & owner & err_q;
  assign m0.rdata  = (rsp & ~owner) ? rdata_q : '0;
  assign m1.rdata  = (rsp & owner) ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter.
// Byte-addressed little-endian memory model on the mem_* side.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        mem_adtp;
  logic [31:0] mem_rd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt = 0;
  int dual_cnt = 0;

  logic [7:0] tbmem [0:131071];

  always #5 clk = ~clk;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0_if.slave),
    .m1       (m1_if.slave),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_adtp (mem_adtp),
    .mem_rd   (mem_rd)
  );

  function automatic logic [16:0] ix(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = a + 32'(k);
    return s[16:0];
  endfunction

  assign mem_rd = mem_adtp ? {24'h0, tbmem[ix(mem_a, 0)]} :
                  {tbmem[ix(mem_a, 3)], tbmem[ix(mem_a, 2)],
                   tbmem[ix(mem_a, 1)], tbmem[ix(mem_a, 0)]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_adtp) begin
        tbmem[ix(mem_a, 0)] <= mem_wd[7:0];
      end else begin
        tbmem[ix(mem_a, 0)] <= mem_wd[7:0];
        tbmem[ix(mem_a, 1)] <= mem_wd[15:8];
        tbmem[ix(mem_a, 2)] <= mem_wd[23:16];
        tbmem[ix(mem_a, 3)] <= mem_wd[31:24];
      end
    end
    if ((m0_if.gnt && m1_if.gnt) || (m0_if.rvalid && m1_if.rvalid))
      dual_cnt <= dual_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input logic req, input logic we,
                       input logic adtp, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (!m) begin
      m0_if.req = req; m0_if.we = we; m0_if.adtp = adtp;
      m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.adtp = adtp;
      m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  // One full transaction; returns grant/rvalid cycle numbers.
  task automatic txn(input bit m, input logic we, input logic adtp,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err,
                     output int gc, output int rc);
    int n;
    gc = -1; rc = -1; rdata = 'x; err = 'x;
    drive(m, 1'b1, we, adtp, addr, wdata);
    n = 0;
    while (gc < 0 && n < 50) begin
      tick; n++;
      if (m ? m1_if.gnt : m0_if.gnt) gc = cyc;
    end
    drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    if (gc < 0) begin
      checks++; errors++;
      $display("FAIL m%0d_gnt_timeout got none want gnt within 50", m);
      return;
    end
    n = 0;
    while (rc < 0 && n < 10) begin
      tick; n++;
      if (m ? m1_if.rvalid : m0_if.rvalid) begin
        rc = cyc;
        rdata = m ? m1_if.rdata : m0_if.rdata;
        err = m ? m1_if.err : m0_if.err;
      end
    end
    if (rc < 0) begin
      checks++; errors++;
      $display("FAIL m%0d_rvalid_timeout got none want rvalid", m);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    logic [34:0] o0, o1;
    logic [65:0] mo;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    o0 = {m0_if.gnt, m0_if.rvalid, m0_if.err, m0_if.rdata};
    o1 = {m1_if.gnt, m1_if.rvalid, m1_if.err, m1_if.rdata};
    mo = {mem_a, mem_wd, mem_we, mem_adtp};
    checks++;
    if (o0 !== '0) begin errors++;
      $display("FAIL reset_m0_outs got %h want 0", o0); end
    checks++;
    if (o1 !== '0) begin errors++;
      $display("FAIL reset_m1_outs got %h want 0", o1); end
    checks++;
    if (mo !== '0) begin errors++;
      $display("FAIL reset_mem_outs got %h want 0", mo); end
    checks++;
    if (dut.state !== IDLE || dut.rr_ptr !== 1'b0) begin errors++;
      $display("FAIL reset_state got st=%0d rr=%b want 0/0",
               dut.state, dut.rr_ptr); end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_word_rw;
    logic [31:0] rd; logic er; int gc, rc, s;
    s = cyc;
    txn(1'b0, 1'b1, 1'b0, 32'h10000, 32'hDEADBEEF, rd, er, gc, rc);
    checks++;
    if (gc - s != 1) begin errors++;
      $display("FAIL word_gnt_latency got %0d want 1", gc - s); end
    checks++;
    if (rc - gc != 1) begin errors++;
      $display("FAIL word_wr_gnt_to_rvalid got %0d want 1", rc - gc); end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin errors++;
      $display("FAIL word_wr_resp got err=%b rd=%h want 0/0", er, rd); end
    txn(1'b0, 1'b0, 1'b0, 32'h10000, 32'h0, rd, er, gc, rc);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++;
      $display("FAIL word_rd got %h err=%b want deadbeef err=0", rd, er); end
    checks++;
    if (rc - gc != 1) begin errors++;
      $display("FAIL word_rd_gnt_to_rvalid got %0d want 1", rc - gc); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int gc, rc;
    txn(1'b1, 1'b1, 1'b1, 32'h10002, 32'hABCDEF55, rd, er, gc, rc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin errors++;
      $display("FAIL byte_wr_resp got err=%b rd=%h want 0/0", er, rd); end
    txn(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0, rd, er, gc, rc);
    checks++;
    if (rd !== 32'hDE55BEEF) begin errors++;
      $display("FAIL byte_then_word_rd got %h want de55beef", rd); end
    txn(1'b1, 1'b0, 1'b1, 32'h10002, 32'h0, rd, er, gc, rc);
    checks++;
    if (rd !== 32'h00000055 || er !== 1'b0) begin errors++;
      $display("FAIL byte_rd got %h err=%b want 00000055/0", rd, er); end
  endtask

  task automatic test_round_robin;
    logic [31:0] r0a, r0b, r1a, r1b; logic e0a, e0b, e1a, e1b;
    int g0a, g0b, g1a, g1b, c0a, c0b, c1a, c1b;
    logic [31:0] rd; logic er; int gc, rc;
    do_reset;
    fork
      begin
        txn(1'b0, 1'b1, 1'b0, 32'h100, 32'h11111111, r0a, e0a, g0a, c0a);
        txn(1'b0, 1'b1, 1'b0, 32'h104, 32'h22222222, r0b, e0b, g0b, c0b);
      end
      begin
        txn(1'b1, 1'b1, 1'b0, 32'h200, 32'h33333333, r1a, e1a, g1a, c1a);
        txn(1'b1, 1'b1, 1'b0, 32'h204, 32'h44444444, r1b, e1b, g1b, c1b);
      end
    join
    checks++;
    if (g1a - g0a != 3) begin errors++;
      $display("FAIL rr_m0_first got m1-m0=%0d want 3", g1a - g0a); end
    checks++;
    if (g0b - g1a != 3) begin errors++;
      $display("FAIL rr_m1_then_m0 got %0d want 3", g0b - g1a); end
    checks++;
    if (g1b - g0b != 3) begin errors++;
      $display("FAIL rr_last_m1 got %0d want 3", g1b - g0b); end
    txn(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, rd, er, gc, rc);
    checks++;
    if (rd !== 32'h22222222) begin errors++;
      $display("FAIL rr_readback got %h want 22222222", rd); end
  endtask

  task automatic test_range;
    logic [31:0] rd; logic er; int gc, rc, w0;
    w0 = we_cnt;
    txn(1'b0, 1'b1, 1'b0, 32'h1FFFE, 32'hCAFEF00D, rd, er, gc, rc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL range_wr_err got err=%b rd=%h want 1/0", er, rd); end
    checks++;
    if (we_cnt != w0 || tbmem[17'h1FFFE] !== 8'h33) begin errors++;
      $display("FAIL range_no_write got we=%0d mem=%h want 0/33",
               we_cnt - w0, tbmem[17'h1FFFE]); end
    txn(1'b0, 1'b0, 1'b1, 32'h1FFFF, 32'h0, rd, er, gc, rc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h000000A5) begin errors++;
      $display("FAIL range_byte_top got err=%b rd=%h want 0/a5", er, rd); end
    txn(1'b1, 1'b0, 1'b0, 32'h1FFFC, 32'h0, rd, er, gc, rc);
    checks++;
    if (er !== 1'b0 || rd !== 32'hA5332211) begin errors++;
      $display("FAIL range_word_top got err=%b rd=%h want 0/a5332211",
               er, rd); end
    txn(1'b1, 1'b0, 1'b0, 32'h1FFFD, 32'h0, rd, er, gc, rc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL range_word_over got err=%b rd=%h want 1/0", er, rd); end
    txn(1'b0, 1'b0, 1'b1, 32'h20000, 32'h0, rd, er, gc, rc);
    checks++;
    if (er !== 1'b1) begin errors++;
      $display("FAIL range_byte_over got err=%b want 1", er); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int gc, rc, n; bit seen;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10000, 32'h12345678);
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      tick; n++;
      seen = m0_if.gnt;
    end
    checks++;
    if (!seen || mem_we !== 1'b1) begin errors++;
      $display("FAIL rstmid_access got gnt=%b we=%b want 1/1", seen, mem_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || dut.state !== IDLE) begin errors++;
      $display("FAIL rstmid_async got we=%b st=%0d want 0/IDLE",
               mem_we, dut.state); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick; tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (m0_if.rvalid || m1_if.rvalid) seen = 1;
    end
    checks++;
    if (seen) begin errors++;
      $display("FAIL rstmid_no_rvalid got rvalid want none"); end
    txn(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0, rd, er, gc, rc);
    checks++;
    if (rd !== 32'hDE55BEEF) begin errors++;
      $display("FAIL rstmid_mem_kept got %h want de55beef", rd); end
  endtask

  task automatic test_stream;
    logic [31:0] rd, rd0, rda, rdb; logic er, e0, ea, eb;
    int g[3]; int gc, rc, g0, r0, ha, hb, ra, rb;
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0, rd, er, gc, rc);
      g[i] = gc;
    end
    checks++;
    if (g[1] - g[0] != 3 || g[2] - g[1] != 3) begin errors++;
      $display("FAIL stream_m1_period got %0d,%0d want 3,3",
               g[1] - g[0], g[2] - g[1]); end
    fork
      begin
        txn(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0, rda, ea, ha, ra);
        txn(1'b1, 1'b0, 1'b1, 32'h10003, 32'h0, rdb, eb, hb, rb);
      end
      begin
        tick; tick;
        txn(1'b0, 1'b0, 1'b1, 32'h10001, 32'h0, rd0, e0, g0, r0);
      end
    join
    checks++;
    if (g0 - ha != 3 || hb - g0 != 3) begin errors++;
      $display("FAIL stream_m0_cut_in got %0d,%0d want 3,3",
               g0 - ha, hb - g0); end
    checks++;
    if (rd0 !== 32'h000000BE || rdb !== 32'h000000DE) begin errors++;
      $display("FAIL stream_data got m0=%h m1=%h want be/de", rd0, rdb); end
  endtask

  initial begin
    tbmem[17'h1FFFC] = 8'h11;
    tbmem[17'h1FFFD] = 8'h22;
    tbmem[17'h1FFFE] = 8'h33;
    tbmem[17'h1FFFF] = 8'hA5;
    test_reset;
    test_word_rw;
    test_byte;
    test_round_robin;
    test_range;
    test_reset_mid;
    test_stream;
    checks++;
    if (dual_cnt != 0) begin errors++;
      $display("FAIL dual_pulse got %0d cycles want 0", dual_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
